lns_mul_stage: RTL
==================

# lns_mul_stage

Pipelined LNS multiply stage directly upstream of `Adder` in the fused multiply-add datapath. It takes an operand triple (a, b, c) in the 12-bit LNS format and forms the product p = a·b by adding log magnitudes, with saturation. It then presents {p, c} to `Adder` as its x/y pair. Throughput is one triple per cycle with valid/ready flow control, and sticky overflow/underflow status is kept.

## Interface
Parameters:
- `LOG_W`, default 11: signed log-magnitude width. The value is fixed point with 7 fractional bits (ε = 2^-7).
- `W`, default 12: word width, `{sign, log[LOG_W-1:0]}`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand triple valid.
- `in_ready`  out  1  stage can accept a triple this cycle.
- `a`  in  W  multiplicand, `{sign, log}`.
- `b`  in  W  multiplier, `{sign, log}`.
- `c`  in  W  addend, passed through unmodified.
- `out_valid`  out  1  `p`/`c_out` valid.
- `out_ready`  in  1  the `Adder` side consumes the current output.
- `p`  out  W  product, drives `Adder.x`.
- `c_out`  out  W  delayed addend, drives `Adder.y`.
- `p_ovf`  out  1  the current `p` saturated high (qualified by `out_valid`).
- `p_unf`  out  1  the current `p` saturated low (qualified by `out_valid`).
- `ovf_sticky`  out  1  set by any accepted-out product with `p_ovf` set.
- `unf_sticky`  out  1  set by any accepted-out product with `p_unf` set.
- `clr_sticky`  in  1  clears both sticky flags.

## Operation
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Sign of the product: `p[W-1] = a[W-1] ^ b[W-1]`.
- Log magnitude of the product:
  - Compute `s = sext(a.log) + sext(b.log)` at LOG_W+1 = 12 bits signed.
  - If `s > 1023`: `p.log = 1023`, `p_ovf = 1`.
  - If `s < -1024`: `p.log = -1024`, `p_unf = 1`.
  - Otherwise: `p.log = s[LOG_W-1:0]`.
  - `p_ovf` and `p_unf` are never both set.
- `c` is carried alongside its triple bit-exact.
- Ordering is strictly in order. No triple is dropped or duplicated.
- Sticky flags:
  - Set on an output transfer whose flag is set.
  - `clr_sticky` has priority over a same-cycle set.
  - Set only at an output transfer, so a stalled saturated product is counted once.

## Timing
- Pipeline structure: 2 register stages.
  - S1 registers a/b/c.
  - S2 registers the saturated p, c, and the flags.
  - Arithmetic sits between S1 and S2.
- Latency: 2 cycles from an input transfer to `out_valid` when there is no stall.
- Each stage holds one valid bit.
  - A stage loads when it is empty or its content moves forward in the same cycle.
  - S2 advances when `out_ready` or `!out_valid`.
  - S1 advances when S2 can load.
- `in_ready = !s1_valid || s2_can_load`. It is combinational from `out_ready`. The bubble is collapsed: full throughput at `out_ready = 1`.
- Under sustained `out_ready = 0`:
  - Two triples are held.
  - `in_ready` falls in the cycle after the second is accepted.
  - `p`, `c_out`, `p_ovf` and `p_unf` stay stable while `out_valid && !out_ready`.
- When `out_ready` rises, one output per cycle follows, and `in_ready` rises in the same cycle.
- Reset values:
  - `out_valid`, `ovf_sticky`, `unf_sticky` = 0.
  - `p`, `c_out` = 0.
  - `p_ovf`, `p_unf` = 0.
  - Both stage valid bits = 0.
  - `in_ready` = 1 from the first cycle after `rst`.
- Reset mid-operation discards all in-flight triples. No output is produced for them.
- Simultaneous accept and emit in the same cycle are both honoured.

## Structure
- Shared package `lns_pkg`:
  - `LOG_W`, `W`, `EPS_FRAC = 7`.
  - `LOG_MAX = 1023`, `LOG_MIN = -1024`.
  - Typedef `lns_t` (packed struct: `sign`, signed `log`).
  - Function `lns_sat_log` (12-bit sum → log + ovf/unf).
- One natural sub-module, `lns_log_mul`, which is combinational: sign XOR, 12-bit add, saturate. `Adder` will reuse it for its own exponent path checks.
- The handshake pipeline stays in `lns_mul_stage`.

## Test plan
- `a = 12'h000` (1.0), `b = 12'h080` (2.0), `c = 12'h123`, `out_ready = 1` → after 2 cycles: `p = 12'h080`, `c_out = 12'h123`, `p_ovf = 0`, `p_unf = 0`.
- `a = 12'h880` (−2.0), `b = 12'h100` (4.0) → `p = 12'h980` (−8.0).
- `a.log = 1000`, `b.log = 100` → `p.log = 1023` (`12'h3FF` for positive signs), `p_ovf = 1`, `ovf_sticky = 1` after transfer. Then `clr_sticky` → 0.
- `a.log = -1000`, `b.log = -100` → `p.log = -1024` (`12'h400`), `p_unf = 1`, `unf_sticky = 1`. Then `a.log = -1000`, `b.log = -24` → exactly -1024, `p_unf = 0`.
- Back-to-back stream of 6 triples with `out_ready = 0` for cycles 3–8:
  - `in_ready` drops after 2 accepts.
  - Outputs hold stable.
  - All 6 emerge in order with no gaps once `out_ready = 1`.
- Assert `rst` for 1 cycle with 2 triples in flight → `out_valid = 0` the next cycle, stickies 0, `in_ready = 1`, no stale output ever appears.

Source files
------------

// File: rtl/lns_pkg.sv
// rtl/lns_pkg.sv - shared LNS word format, limits and log saturation helper
package lns_pkg;
  localparam int LOG_W    = 11;
  localparam int W        = 12;
  localparam int EPS_FRAC = 7;
  localparam int LOG_MAX  = 1023;
  localparam int LOG_MIN  = -1024;

  localparam logic signed [LOG_W:0] SUM_MAX = (LOG_W+1)'(LOG_MAX);
  localparam logic signed [LOG_W:0] SUM_MIN = (LOG_W+1)'(LOG_MIN);

  typedef struct packed {
    logic                    sign;
    logic signed [LOG_W-1:0] log;
  } lns_t;

  typedef struct packed {
    logic                    ovf;
    logic                    unf;
    logic signed [LOG_W-1:0] log;
  } sat_log_t;

  // Clamp a one-bit-wider log sum back into the LNS log range.
  function automatic sat_log_t lns_sat_log(input logic signed [LOG_W:0] s);
    sat_log_t r;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    r.log = s[LOG_W-1:0];
    if (s > SUM_MAX) begin
      r.ovf = 1'b1;
      r.log = (LOG_W)'(LOG_MAX);
    end else if (s < SUM_MIN) begin
      r.unf = 1'b1;
      r.log = (LOG_W)'(LOG_MIN);
    end
    return r;
  endfunction
endpackage

// File: rtl/lns_log_mul.sv
// rtl/lns_log_mul.sv - combinational LNS multiply: sign xor, log add, saturate
module lns_log_mul
  import lns_pkg::*;
(
  input  lns_t a,
  input  lns_t b,
  output lns_t p,
  output logic ovf,
  output logic unf
);
  logic signed [LOG_W:0] sum;
  sat_log_t              sat;

  always_comb begin
    sum    = {a.log[LOG_W-1], a.log} + {b.log[LOG_W-1], b.log};
    sat    = lns_sat_log(sum);
    p.sign = a.sign ^ b.sign;
    p.log  = sat.log;
    ovf    = sat.ovf;
    unf    = sat.unf;
  end
endmodule

// File: rtl/lns_mul_stage.sv
// rtl/lns_mul_stage.sv - two-stage valid/ready LNS multiply feeding the adder
module lns_mul_stage
  import lns_pkg::*;
#(
  parameter int LOG_W = lns_pkg::LOG_W,
  parameter int W     = lns_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p,
  output logic [W-1:0] c_out,
  output logic         p_ovf,
  output logic         p_unf,
  output logic         ovf_sticky,
  output logic         unf_sticky,
  input  logic         clr_sticky
);
  logic         s1_valid;
  logic [W-1:0] s1_a, s1_b, s1_c;
  logic         s2_can_load;
  lns_t         mul_p;
  logic         mul_ovf, mul_unf;

  lns_log_mul u_log_mul (
    .a   (lns_t'(s1_a)),
    .b   (lns_t'(s1_b)),
    .p   (mul_p),
    .ovf (mul_ovf),
    .unf (mul_unf)
  );

  // S2 frees up in the same cycle it drains, so S1 and the input never bubble.
  assign s2_can_load = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_c       <= '0;
      out_valid  <= 1'b0;
      p          <= '0;
      c_out      <= '0;
      p_ovf      <= 1'b0;
      p_unf      <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (s2_can_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          p     <= W'(mul_p);
          c_out <= s1_c;
          p_ovf <= mul_ovf;
          p_unf <= mul_unf;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a <= a;
          s1_b <= b;
          s1_c <= c;
        end
      end
      // Flags count only when a product leaves, so a stalled one is seen once.
      if (clr_sticky) begin
        ovf_sticky <= 1'b0;
        unf_sticky <= 1'b0;
      end else if (out_valid && out_ready) begin
        if (p_ovf) ovf_sticky <= 1'b1;
        if (p_unf) unf_sticky <= 1'b1;
      end
    end
  end
endmodule
